// File: rtl/uart_fmt_pkg.sv
// Shared types and ASCII constants for the hex message formatter.
// The terminator length follows the UART_HEX_FMT_CRLF_EN build macro.
package uart_fmt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        FIN
    } fmt_state_t;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_A  = 8'h41;

    function automatic int term_len();
`ifdef UART_HEX_FMT_CRLF_EN
        return 2;
`else
        return 1;
`endif
    endfunction

endpackage

// File: rtl/hex_ascii.sv
// Combinational nibble to upper-case ASCII hex digit.
module hex_ascii
    import uart_fmt_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10)
            ascii = CHAR_0 + {4'h0, nibble};
        else
            ascii = CHAR_A + {4'h0, nibble} - 8'd10;
    end

endmodule

// File: rtl/uart_hex_fmt.sv
// Prints a latched word as upper-case hex plus line terminator through uart_tx.
// Build macro UART_HEX_FMT_CRLF_EN selects a CR LF terminator instead of LF alone.
module uart_hex_fmt
    import uart_fmt_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [4*NIBBLES-1:0] word,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           data,
    output logic                 start,
    input  logic                 ready
);

    localparam int WORD_W = 4 * NIBBLES;
    localparam int IDX_W  = $clog2(NIBBLES + 2);
    localparam logic [IDX_W-1:0] TERM_IDX = IDX_W'(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES + term_len() - 1);

    fmt_state_t        state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic [7:0]        data_n;
    logic              start_n, done_n, busy_n;
    logic [7:0]        hex_char, cur_char;

    hex_ascii u_hex_ascii (
        .nibble (shreg[WORD_W-1 -: 4]),
        .ascii  (hex_char)
    );

    // Digits come from the top nibble; indices past the digits select the terminator.
    always_comb begin
        cur_char = CHAR_LF;
        if (idx < TERM_IDX)
            cur_char = hex_char;
`ifdef UART_HEX_FMT_CRLF_EN
        else if (idx == TERM_IDX)
            cur_char = CHAR_CR;
`endif
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data;
        start_n = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    shreg_n = word;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (ready) begin
                    start_n = 1'b1;
                    data_n  = cur_char;
                    state_n = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!ready)
                    state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ready) begin
                    if (idx == LAST_IDX) begin
                        state_n = FIN;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        shreg_n = shreg << 4;
                        state_n = SEND;
                    end
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // done marks the FIN cycle; busy covers every non-idle cycle including FIN.
        done_n = (state_n == FIN);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            start <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            data  <= 8'h00;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            start <= start_n;
            done  <= done_n;
            busy  <= busy_n;
            data  <= data_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

endmodule

// File: tb/tb_uart_hex_fmt.sv
// Bench for uart_hex_fmt: behavioural uart_tx models, character scoreboards, table of words.
module tb_uart_hex_fmt;

`ifdef UART_HEX_FMT_CRLF_EN
    localparam int TERM = 2;
`else
    localparam int TERM = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req1;
    logic [15:0] word;
    logic [3:0]  word1;
    logic        busy, done, start, ready;
    logic        busy1, done1, start1, ready1;
    logic [7:0]  data, data1;
    logic        hold_low;
    int          tx_cnt = 0, tx_cnt1 = 0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q1[$];
    int start_cnt = 0, done_cnt = 0, start_cnt1 = 0, done_cnt1 = 0;
    logic prev_start = 1'b0, prev_done = 1'b0;
    logic [7:0] last_data = 8'h00;

    typedef struct {
        logic [15:0] w;
        string       txt;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_hex_fmt #(.NIBBLES(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .word  (word),
        .busy  (busy),
        .done  (done),
        .data  (data),
        .start (start),
        .ready (ready)
    );

    uart_hex_fmt #(.NIBBLES(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req1),
        .word  (word1),
        .busy  (busy1),
        .done  (done1),
        .data  (data1),
        .start (start1),
        .ready (ready1)
    );

    // uart_tx stand-ins: ready drops for 10 cycles after each start pulse.
    assign ready  = (tx_cnt == 0) && !hold_low;
    assign ready1 = (tx_cnt1 == 0);

    always @(posedge clk) begin
        if (start === 1'b1)   tx_cnt <= 10;
        else if (tx_cnt > 0)  tx_cnt <= tx_cnt - 1;
        if (start1 === 1'b1)  tx_cnt1 <= 10;
        else if (tx_cnt1 > 0) tx_cnt1 <= tx_cnt1 - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (start) begin
                check("start_single", 32'(prev_start), 32'd0);
                check("busy_at_start", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual=%0h required=no_start", data);
                end else begin
                    check("char", 32'(data), 32'(exp_q.pop_front()));
                end
                start_cnt <= start_cnt + 1;
                last_data <= data;
            end else begin
                if (busy && tx_cnt > 0)
                    check("data_hold", 32'(data), 32'(last_data));
                if (!busy)
                    last_data <= data;
            end
            if (done) begin
                check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
                check("busy_at_done", 32'(busy), 32'd1);
                done_cnt <= done_cnt + 1;
            end
            if (prev_done) begin
                check("done_single", 32'(done), 32'd0);
                check("busy_after_done", 32'(busy), 32'd0);
            end
            if (start1) begin
                if (exp_q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start1 actual=%0h required=no_start", data1);
                end else begin
                    check("char1", 32'(data1), 32'(exp_q1.pop_front()));
                end
                start_cnt1 <= start_cnt1 + 1;
            end
            if (done1) begin
                check("queue1_empty_at_done", 32'(exp_q1.size()), 32'd0);
                done_cnt1 <= done_cnt1 + 1;
            end
        end
        prev_start <= start;
        prev_done  <= done;
    end

    task automatic push_msg(input string txt);
        for (int i = 0; i < txt.len(); i++) exp_q.push_back(8'(txt[i]));
`ifdef UART_HEX_FMT_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic send_req(input logic [15:0] w, input string txt);
        @(negedge clk);
        check("idle_before_req", 32'(busy), 32'd0);
        word = w;
        req  = 1'b1;
        push_msg(txt);
        @(negedge clk);
        req  = 1'b0;
        word = 16'($urandom);
        check("busy_after_req", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (start_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL start_timeout actual=%0d required=%0d", start_cnt, target);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, d0;
        vecs[0].w = 16'hA5F0; vecs[0].txt = "A5F0";
        vecs[1].w = 16'h0000; vecs[1].txt = "0000";
        vecs[2].w = 16'hFFFF; vecs[2].txt = "FFFF";
        vecs[3].w = 16'h1234; vecs[3].txt = "1234";
        vecs[4].w = 16'h89BC; vecs[4].txt = "89BC";
        vecs[5].w = 16'h7E6D; vecs[5].txt = "7E6D";

        rst = 1'b1; req = 1'b0; word = 16'h0; hold_low = 1'b0;
        req1 = 1'b0; word1 = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_data",  32'(data),  32'h00);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            s0 = start_cnt;
            d0 = done_cnt;
            send_req(vecs[v].w, vecs[v].txt);
            wait_done(d0, 400);
            check("start_count", 32'(start_cnt - s0), 32'(4 + TERM));
            check("done_count", 32'(done_cnt - d0), 32'd1);
        end

        // Transmitter still busy when the request arrives.
        hold_low = 1'b1;
        s0 = start_cnt;
        d0 = done_cnt;
        send_req(16'h5A3C, "5A3C");
        repeat (20) @(negedge clk);
        check("no_start_while_not_ready", 32'(start_cnt - s0), 32'd0);
        hold_low = 1'b0;
        wait_done(d0, 400);

        // A second request in mid-message is dropped, not queued.
        s0 = start_cnt;
        d0 = done_cnt;
        send_req(16'hBEEF, "BEEF");
        wait_starts(s0 + 2, 200);
        @(negedge clk);
        word = 16'h1234;
        req  = 1'b1;
        @(negedge clk);
        req  = 1'b0;
        wait_done(d0, 400);
        repeat (30) @(negedge clk);
        check("ignored_req_start_count", 32'(start_cnt - s0), 32'(4 + TERM));
        d0 = done_cnt;
        send_req(16'h1234, "1234");
        wait_done(d0, 400);

        // Reset during the third character drops the rest of the message.
        s0 = start_cnt;
        send_req(16'hC0DE, "C0DE");
        wait_starts(s0 + 3, 200);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_start", 32'(start), 32'd0);
        check("midrst_data",  32'(data),  32'h00);
        check("midrst_done",  32'(done),  32'd0);
        rst = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        s0 = start_cnt;
        repeat (30) @(negedge clk);
        check("midrst_no_done",  32'(done_cnt - d0),  32'd0);
        check("midrst_no_start", 32'(start_cnt - s0), 32'd0);
        send_req(16'hFFFF, "FFFF");
        wait_done(d0, 400);
        check("after_rst_done_count", 32'(done_cnt - d0), 32'd1);

        // Single-digit instance.
        for (int v = 0; v < 3; v++) begin
            logic [3:0] nib;
            logic [7:0] ch;
            int n;
            nib = (v == 0) ? 4'h9 : (v == 1) ? 4'h0 : 4'hF;
            ch  = (v == 0) ? 8'h39 : (v == 1) ? 8'h30 : 8'h46;
            s0 = start_cnt1;
            d0 = done_cnt1;
            @(negedge clk);
            word1 = nib;
            req1  = 1'b1;
            exp_q1.push_back(ch);
`ifdef UART_HEX_FMT_CRLF_EN
            exp_q1.push_back(8'h0D);
`endif
            exp_q1.push_back(8'h0A);
            @(negedge clk);
            req1 = 1'b0;
            check("busy1_after_req", 32'(busy1), 32'd1);
            n = 0;
            while (done_cnt1 == d0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("done1_seen", 32'(done_cnt1 - d0), 32'd1);
            check("start1_count", 32'(start_cnt1 - s0), 32'(1 + TERM));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
